// File: rtl/clk_period_meter_pkg.sv
// Shared definitions for the divided-clock period meter: FSM encoding and
// default widths.
package clk_period_meter_pkg;

  localparam int unsigned CW_DEFAULT          = 16;
  localparam int unsigned SYNC_STAGES_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_e;

endpackage

// File: rtl/clk_period_meter_sync_edge.sv
// Synchronizer chain plus registered rise detect for an asynchronous level.
// Ports:
//   clk, rst_n : clock, async active-low clear
//   d_i        : asynchronous input level
//   qs_o       : synchronized level, delayed to line up with rise_o
//   rise_o     : one-cycle pulse for each 0->1 transition of the level
module clk_period_meter_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic qs_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   qs;
  logic                   qd_q;
  logic                   rise_q;

  assign qs = sync_q[SYNC_STAGES-1];

  // Sync chain, delayed copy and rise pulse; qd_q is the level in the same
  // cycle rise_q is asserted, so consumers see a consistent pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      qd_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      qd_q   <= qs;
      rise_q <= qs & ~qd_q;
    end
  end

  assign qs_o   = qd_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of an asynchronous divided clock in CLK
// cycles, one result per input period.
// Ports:
//   CLK, CL : reference clock, async active-low clear
//   EN      : measurement enable (low returns to IDLE)
//   QIN     : divided clock under test (asynchronous)
//   PERIOD  : last complete period, rising edge to rising edge
//   HIGHT   : high-phase cycles within that period
//   VALID   : one-cycle pulse when PERIOD/HIGHT update
//   OVF     : sticky, period counter saturated before the next rise
//   BUSY    : FSM in ARM or MEAS
module clk_period_meter
  import clk_period_meter_pkg::*;
#(
  parameter int unsigned CW          = CW_DEFAULT,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic          CLK,
  input  logic          CL,
  input  logic          EN,
  input  logic          QIN,
  output logic [CW-1:0] PERIOD,
  output logic [CW-1:0] HIGHT,
  output logic          VALID,
  output logic          OVF,
  output logic          BUSY
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          qs;
  logic          rise;

  state_e        state_q,  state_d;
  logic [CW-1:0] pcnt_q,   pcnt_d;
  logic [CW-1:0] hcnt_q,   hcnt_d;
  logic [CW-1:0] period_q, period_d;
  logic [CW-1:0] hight_q,  hight_d;
  logic          valid_q,  valid_d;
  logic          ovf_q,    ovf_d;
  logic          busy_q,   busy_d;

  clk_period_meter_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk   (CLK),
    .rst_n (CL),
    .d_i   (QIN),
    .qs_o  (qs),
    .rise_o(rise)
  );

  // Next-state, counters and result update.
  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    hcnt_d   = hcnt_q;
    period_d = period_q;
    hight_d  = hight_q;
    valid_d  = 1'b0;
    ovf_d    = ovf_q;

    if (!EN) begin
      // Any partial measurement is dropped; results hold.
      state_d = IDLE;
      pcnt_d  = '0;
      hcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ARM;
          pcnt_d  = '0;
          hcnt_d  = '0;
          ovf_d   = 1'b0;
        end
        ARM: begin
          if (rise) begin
            pcnt_d  = CNT_ONE;
            hcnt_d  = CNT_ONE;
            state_d = MEAS;
          end
        end
        MEAS: begin
          // A rise at the saturation point still yields a valid result.
          if (rise) begin
            period_d = pcnt_q;
            hight_d  = hcnt_q;
            valid_d  = 1'b1;
            pcnt_d   = CNT_ONE;
            hcnt_d   = CNT_ONE;
          end else if (pcnt_q == CNT_MAX) begin
            ovf_d   = 1'b1;
            pcnt_d  = '0;
            hcnt_d  = '0;
            state_d = ARM;
          end else begin
            pcnt_d = pcnt_q + CNT_ONE;
            if (qs) begin
              hcnt_d = hcnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          pcnt_d  = '0;
          hcnt_d  = '0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge CL) begin
    if (!CL) begin
      state_q  <= IDLE;
      pcnt_q   <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      hight_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      hight_q  <= hight_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
    end
  end

  assign PERIOD = period_q;
  assign HIGHT  = hight_q;
  assign VALID  = valid_q;
  assign OVF    = ovf_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Testbench for clk_period_meter: QIN is built from (high, low) segments and
// every complete segment must come back as one result, at a fixed latency.
module tb_clk_period_meter;

  localparam int unsigned CW = 8;
  localparam int unsigned SS = 2;

  logic          CLK = 1'b0;
  logic          CL  = 1'b0;
  logic          EN  = 1'b0;
  logic          QIN = 1'b0;
  logic [CW-1:0] PERIOD;
  logic [CW-1:0] HIGHT;
  logic          VALID;
  logic          OVF;
  logic          BUSY;

  clk_period_meter #(
    .CW         (CW),
    .SYNC_STAGES(SS)
  ) dut (
    .CLK   (CLK),
    .CL    (CL),
    .EN    (EN),
    .QIN   (QIN),
    .PERIOD(PERIOD),
    .HIGHT (HIGHT),
    .VALID (VALID),
    .OVF   (OVF),
    .BUSY  (BUSY)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Log every result with the cycle it appeared in.
  int unsigned cap_p[$];
  int unsigned cap_h[$];
  int unsigned cap_t[$];
  logic        prev_v = 1'b0;
  int unsigned dbl    = 0;
  always @(negedge CLK) begin
    if (VALID) begin
      cap_p.push_back(int'(PERIOD));
      cap_h.push_back(int'(HIGHT));
      cap_t.push_back(cyc);
    end
    if (VALID && prev_v) dbl = dbl + 1;
    prev_v = VALID;
  end

  int          total = 0;
  int          bad   = 0;
  int unsigned seg_h[$];
  int unsigned seg_l[$];
  int unsigned p_last = 0;
  int unsigned h_last = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_level(input logic v, input int unsigned n);
    QIN = v;
    repeat (n) @(negedge CLK);
  endtask

  task automatic en_cycle();
    EN = 1'b0;
    repeat (2) @(negedge CLK);
    EN = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic clear_segs();
    seg_h.delete();
    seg_l.delete();
  endtask

  task automatic add_seg(input int unsigned h, input int unsigned l, input int unsigned cnt);
    for (int k = 0; k < int'(cnt); k++) begin
      seg_h.push_back(h);
      seg_l.push_back(l);
    end
  endtask

  // Drive the segments plus a closing rise; each segment is one result whose
  // VALID follows the next rise by SS+2 cycles.
  task automatic run_phase(input string tag);
    int unsigned rc[$];
    int unsigned start;
    int unsigned n;
    int unsigned got;
    start = cap_p.size();
    n     = seg_h.size();
    foreach (seg_h[i]) begin
      rc.push_back(cyc);
      drive_level(1'b1, seg_h[i]);
      drive_level(1'b0, seg_l[i]);
    end
    rc.push_back(cyc);
    drive_level(1'b1, 1);
    drive_level(1'b0, 8);
    got = cap_p.size() - start;
    chk({tag, "_count"}, got, n);
    for (int i = 0; i < int'(n) && i < int'(got); i++) begin
      chk({tag, "_period"}, cap_p[start+i], seg_h[i] + seg_l[i]);
      chk({tag, "_hight"},  cap_h[start+i], seg_h[i]);
      chk({tag, "_time"},   cap_t[start+i], rc[i+1] + SS + 2);
    end
    chk({tag, "_b2b"}, dbl, 0);
    if (n > 0) begin
      p_last = seg_h[n-1] + seg_l[n-1];
      h_last = seg_h[n-1];
    end
  endtask

  initial begin
    int unsigned c0;
    int unsigned n0;

    repeat (3) @(negedge CLK);
    chk("rst_period", PERIOD, 0);
    chk("rst_hight",  HIGHT,  0);
    chk("rst_valid",  VALID,  0);
    chk("rst_ovf",    OVF,    0);
    chk("rst_busy",   BUSY,   0);
    CL = 1'b1;
    @(negedge CLK);
    chk("idle_busy", BUSY, 0);
    EN = 1'b1;
    repeat (2) @(negedge CLK);
    chk("arm_busy", BUSY, 1);

    // CLK/16, 50% duty
    clear_segs();
    add_seg(8, 8, 5);
    run_phase("div16");
    chk("div16_ovf", OVF, 0);

    // ratio 15 (high 7) then changed to 10 mid-run
    en_cycle();
    clear_segs();
    add_seg(7, 8, 3);
    add_seg(5, 5, 3);
    run_phase("ratio");

    // random duty/period
    for (int k = 0; k < 3; k++) begin
      en_cycle();
      clear_segs();
      for (int j = 0; j < 5; j++) add_seg($urandom_range(30, 1), $urandom_range(30, 1), 1);
      run_phase("rand");
    end

    // single rise then held low: saturation after 255 cycles in MEAS
    en_cycle();
    n0 = cap_p.size();
    c0 = cyc;
    drive_level(1'b1, 1);
    QIN = 1'b0;
    while (cyc < c0 + 258) @(negedge CLK);
    chk("ovf_before", OVF, 0);
    @(negedge CLK);
    chk("ovf_set",     OVF,    1);
    chk("ovf_busy",    BUSY,   1);
    chk("ovf_period",  PERIOD, p_last);
    chk("ovf_hight",   HIGHT,  h_last);
    chk("ovf_novalid", cap_p.size(), n0);
    repeat (3) @(negedge CLK);
    clear_segs();
    add_seg(20, 20, 2);
    run_phase("after_ovf");
    chk("ovf_sticky", OVF, 1);
    en_cycle();
    chk("ovf_clear", OVF, 0);

    // EN dropped mid-period
    clear_segs();
    add_seg(6, 6, 3);
    run_phase("endrop");
    EN = 1'b0;
    @(negedge CLK);
    chk("endrop_busy", BUSY, 0);
    n0 = cap_p.size();
    for (int j = 0; j < 3; j++) begin
      drive_level(1'b1, 4);
      drive_level(1'b0, 4);
    end
    chk("endrop_novalid", cap_p.size(), n0);
    chk("endrop_period",  PERIOD, 12);
    chk("endrop_hight",   HIGHT,  6);
    EN = 1'b1;
    repeat (2) @(negedge CLK);
    chk("reen_busy", BUSY, 1);
    clear_segs();
    add_seg(9, 3, 3);
    run_phase("reen");

    // async clear mid-measurement
    en_cycle();
    drive_level(1'b1, 10);
    drive_level(1'b0, 10);
    drive_level(1'b1, 10);
    drive_level(1'b0, 3);
    @(posedge CLK);
    #2 CL = 1'b0;
    #1;
    chk("clr_period", PERIOD, 0);
    chk("clr_hight",  HIGHT,  0);
    chk("clr_valid",  VALID,  0);
    chk("clr_ovf",    OVF,    0);
    chk("clr_busy",   BUSY,   0);
    @(negedge CLK);
    CL = 1'b1;
    repeat (3) @(negedge CLK);
    clear_segs();
    for (int j = 0; j < 4; j++) add_seg($urandom_range(20, 1), $urandom_range(20, 1), 1);
    run_phase("after_clr");

    // fastest measurable input
    en_cycle();
    clear_segs();
    add_seg(1, 1, 6);
    run_phase("p2");

    // rise coincides with saturation
    en_cycle();
    clear_segs();
    add_seg(100, 155, 2);
    run_phase("p255");
    chk("p255_ovf", OVF, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
